// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS single-cycle datapath.
//   ADDR_W       - byte-address width
//   addr_t       - byte address type
//   RESET_VECTOR - boot fetch address
//   INSTR_BYTES  - size of one instruction word in bytes
package mips_pkg;

  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t RESET_VECTOR = 32'h0000_0000;
  localparam int    INSTR_BYTES  = 4;

endpackage

// File: rtl/program_counter.sv
// Program counter register for the MIPS single-cycle datapath.
// Captures the upstream next-PC every rising edge and presents it as the
// fetch address. No enable/stall: the register loads every cycle.
//   clk          - clock, all updates on the rising edge
//   rst          - synchronous active-high reset, loads RESET_VECTOR
//   next_address - address to load at the next rising edge
//   address      - current PC, straight from the register
module program_counter #(
  parameter int                  ADDR_W       = mips_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]   RESET_VECTOR = mips_pkg::RESET_VECTOR,
  parameter int                  FORCE_ALIGN  = 1,
  parameter int                  CHECK_EN     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] next_address,
  output logic [ADDR_W-1:0] address
);

  import mips_pkg::*;

  // Number of byte-offset bits inside one instruction word.
  localparam int ALIGN_LSB = $clog2(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    {{(ADDR_W-ALIGN_LSB){1'b1}}, {ALIGN_LSB{1'b0}}};

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = next_address;
    if (FORCE_ALIGN != 0) pc_d = next_address & ALIGN_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_d;
  end

  assign address = pc_q;

`ifndef SYNTHESIS
  generate
    if (CHECK_EN != 0) begin : g_chk
      // rst seen at the previous edge, and whether any reset has happened yet
      // (inputs before the first reset are allowed to be unknown).
      logic rst_prev_q;
      logic seen_rst_q;

      always_ff @(posedge clk) begin
        rst_prev_q <= rst;
        if (rst) seen_rst_q <= 1'b1;

        if (!rst) begin
          assert ((next_address & ~ALIGN_MASK) == '0)
            else $error("program_counter: misaligned next_address %h", next_address);
          if (seen_rst_q)
            assert (!$isunknown(next_address))
              else $error("program_counter: unknown next_address after reset");
        end
        // address still holds the value loaded at the previous edge here.
        if (rst_prev_q)
          assert (address == RESET_VECTOR)
            else $error("program_counter: address %h not reset vector", address);
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;
  import mips_pkg::*;

  localparam addr_t RV_RAW = 32'hBFC0_0000;

  logic  clk, rst;
  addr_t na_dut, na_any;
  addr_t addr_dut, addr_raw, addr_aln;

  int total = 0;
  int bad   = 0;

  // Default instance with checks on: only ever fed word-aligned addresses.
  program_counter u_dut (
    .clk(clk), .rst(rst), .next_address(na_dut), .address(addr_dut));

  // Unaligned pass-through, non-zero boot vector.
  program_counter #(.RESET_VECTOR(RV_RAW), .FORCE_ALIGN(0), .CHECK_EN(0)) u_raw (
    .clk(clk), .rst(rst), .next_address(na_any), .address(addr_raw));

  // Aligning instance fed arbitrary addresses.
  program_counter #(.FORCE_ALIGN(1), .CHECK_EN(0)) u_aln (
    .clk(clk), .rst(rst), .next_address(na_any), .address(addr_aln));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: expected address of each instance.
  addr_t m_dut, m_raw, m_aln;

  task automatic chk(input string tag, input addr_t got, input addr_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs, confirm outputs do not follow them before the edge,
  // then clock and compare against the model.
  task automatic tick(input logic r, input addr_t a, input addr_t b, input bit hold_chk);
    rst = r; na_dut = a; na_any = b;
    #1;
    if (hold_chk) begin
      chk("hold_dut", addr_dut, m_dut);
      chk("hold_raw", addr_raw, m_raw);
    end
    @(posedge clk);
    if (r) begin
      m_dut = RESET_VECTOR; m_raw = RV_RAW; m_aln = RESET_VECTOR;
    end else begin
      m_dut = a; m_raw = b; m_aln = (b / INSTR_BYTES) * INSTR_BYTES;
    end
    #1;
    chk("dut", addr_dut, m_dut);
    chk("raw", addr_raw, m_raw);
    chk("aln", addr_aln, m_aln);
  endtask

  initial begin
    rst = 1'b1; na_dut = '0; na_any = '0;
    m_dut = '0; m_raw = '0; m_aln = '0;

    // Reset then load.
    tick(1'b1, 32'h0, 32'h0, 1'b0);
    tick(1'b0, 32'h4, 32'h4, 1'b1);

    // Sequential fetch 0..0x3C.
    for (int i = 0; i < 16; i++) begin
      addr_t v;
      v = addr_t'(i * 4);
      tick(1'b0, v, v, 1'b1);
    end

    // Reset mid-run: at 0x38, assert rst with 0x3C pending, hold a few cycles.
    tick(1'b0, 32'h38, 32'h38, 1'b1);
    tick(1'b1, 32'h3C, 32'h3C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      addr_t v;
      v = addr_t'(32'h40 + i * 4);
      tick(1'b1, v, v, 1'b1);
    end
    // Release.
    tick(1'b0, 32'h100, 32'h100, 1'b1);

    // Wrap boundary.
    tick(1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    tick(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1);

    // Alignment: aligning instance drops the low bits, raw keeps them.
    tick(1'b0, 32'h0000_0004, 32'h0000_0006, 1'b1);
    chk("align_fixed", addr_aln, 32'h0000_0004);
    chk("align_raw",   addr_raw, 32'h0000_0006);
    tick(1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 1'b1);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      addr_t a, b;
      logic  r;
      a = addr_t'($urandom) & ~addr_t'(3);
      b = addr_t'($urandom);
      r = ($urandom_range(15) == 0);
      tick(r, a, b, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
